// File: rtl/assoc_cache_controller_if.sv
// Request/response bus between a requester and assoc_cache_controller.
// Carries one outstanding request and its response, plus the read hit/miss statistics.
interface assoc_cache_controller_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_hit;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_hit, hit_cnt, miss_cnt
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_hit, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/assoc_cache_controller.sv
// N-way set-associative, write-through, read-allocate cache with true-LRU replacement,
// fronting a word-addressed backing memory. Read misses cost MISS_LAT extra cycles.
module assoc_cache_controller #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int SETS     = 8,
    parameter int WAYS     = 4,
    parameter int MISS_LAT = 4,
    parameter int CNT_W    = 16
) (
    input logic                     clk,
    input logic                     rst,
    assoc_cache_controller_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int AGE_W = $clog2(WAYS);
    localparam int LAT_W = $clog2(MISS_LAT + 1);

    function automatic logic [WAYS*AGE_W-1:0] age_rst_f();
        logic [WAYS*AGE_W-1:0] v;
        v = '0;
        for (int w = 0; w < WAYS; w++) v[w*AGE_W +: AGE_W] = AGE_W'(w);
        return v;
    endfunction

    // Way i starts at age i so the ages in a set are distinct from the first access.
    localparam logic [WAYS-1:0][AGE_W-1:0] AGE_RST = age_rst_f();

    typedef enum logic [1:0] {IDLE, RESP, FILL} state_t;

    state_t            state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              hit_q, hit_d;
    logic              resp_q, resp_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic [WAYS-1:0]              valid_q [SETS];
    logic [WAYS-1:0]              valid_d [SETS];
    logic [WAYS-1:0][TAG_W-1:0]   tag_q   [SETS];
    logic [WAYS-1:0][TAG_W-1:0]   tag_d   [SETS];
    logic [WAYS-1:0][DATA_W-1:0]  data_q  [SETS];
    logic [WAYS-1:0][DATA_W-1:0]  data_d  [SETS];
    logic [WAYS-1:0][AGE_W-1:0]   age_q   [SETS];
    logic [WAYS-1:0][AGE_W-1:0]   age_d   [SETS];

    logic [DATA_W-1:0] mem_ram [2**ADDR_W];
    logic              mem_we;

    logic [IDX_W-1:0] req_idx, fill_idx, touch_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic [AGE_W-1:0] hit_way, victim, touch_way, touch_age;
    logic             hit_any, free_found, touch_en;

    assign req_idx  = bus.req_addr[IDX_W-1:0];
    assign req_tag  = bus.req_addr[ADDR_W-1:IDX_W];
    assign fill_idx = addr_q[IDX_W-1:0];
    assign fill_tag = addr_q[ADDR_W-1:IDX_W];

    always_comb begin
        hit_any    = 1'b0;
        hit_way    = '0;
        free_found = 1'b0;
        victim     = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit_any = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[fill_idx][w]) begin
                free_found = 1'b1;
                victim     = AGE_W'(w);
            end
        end
        if (!free_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[fill_idx][w] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        addr_d     = addr_q;
        rdata_d    = rdata_q;
        hit_d      = hit_q;
        resp_d     = 1'b0;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        data_d     = data_q;
        age_d      = age_q;
        mem_we     = 1'b0;
        touch_en   = 1'b0;
        touch_idx  = req_idx;
        touch_way  = hit_way;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    if (bus.req_write) begin
                        mem_we  = 1'b1;
                        resp_d  = 1'b1;
                        hit_d   = hit_any;
                        rdata_d = '0;
                        state_d = RESP;
                        if (hit_any) begin
                            data_d[req_idx][hit_way] = bus.req_wdata;
                            touch_en = 1'b1;
                        end
                    end else if (hit_any) begin
                        resp_d   = 1'b1;
                        hit_d    = 1'b1;
                        rdata_d  = data_q[req_idx][hit_way];
                        touch_en = 1'b1;
                        state_d  = RESP;
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                    end else begin
                        lat_d   = LAT_W'(MISS_LAT);
                        state_d = FILL;
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                end
            end
            RESP: state_d = IDLE;
            FILL: begin
                lat_d = lat_q - 1'b1;
                // Response is registered one cycle early so it is visible in the lat==0 cycle.
                if (lat_q == LAT_W'(1)) begin
                    resp_d  = 1'b1;
                    hit_d   = 1'b0;
                    rdata_d = mem_ram[addr_q];
                end
                if (lat_q == '0) begin
                    lat_d                     = '0;
                    state_d                   = IDLE;
                    valid_d[fill_idx][victim] = 1'b1;
                    tag_d[fill_idx][victim]   = fill_tag;
                    data_d[fill_idx][victim]  = mem_ram[addr_q];
                    touch_en                  = 1'b1;
                    touch_idx                 = fill_idx;
                    touch_way                 = victim;
                end
            end
            default: state_d = IDLE;
        endcase

        touch_age = age_q[touch_idx][touch_way];
        if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (AGE_W'(w) == touch_way)
                    age_d[touch_idx][w] = '0;
                else if (age_q[touch_idx][w] < touch_age)
                    age_d[touch_idx][w] = age_q[touch_idx][w] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            addr_q     <= '0;
            rdata_q    <= '0;
            hit_q      <= 1'b0;
            resp_q     <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            valid_q    <= '{default: '0};
            tag_q      <= '{default: '0};
            data_q     <= '{default: '0};
            age_q      <= '{default: AGE_RST};
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            hit_q      <= hit_d;
            resp_q     <= resp_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
            age_q      <= age_d;
        end
    end

    // Backing store keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_ram[bus.req_addr] <= bus.req_wdata;
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_hit   = hit_q;
    assign bus.hit_cnt    = hit_cnt_q;
    assign bus.miss_cnt   = miss_cnt_q;
endmodule

// File: tb/tb_assoc_cache_controller.sv
// Bench for assoc_cache_controller: directed vector table, hand-written corner sequences
// and random traffic against an MRU-ordered tag-list reference model.
module tb_assoc_cache_controller;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 10;
    localparam int SETS     = 8;
    localparam int WAYS     = 4;
    localparam int MISS_LAT = 4;
    localparam int CNT_W    = 16;
    localparam int MEMD     = 1 << ADDR_W;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int SAT_MAX  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    assoc_cache_controller_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
    assoc_cache_controller_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(2))     bus_s ();

    assoc_cache_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS),
                             .MISS_LAT(MISS_LAT), .CNT_W(CNT_W))
        dut (.clk(clk), .rst(rst), .bus(bus.slave));

    // Narrow-counter copy sees identical traffic; only its saturation differs.
    assoc_cache_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS),
                             .MISS_LAT(MISS_LAT), .CNT_W(2))
        dut_s (.clk(clk), .rst(rst), .bus(bus_s.slave));

    assign bus_s.req_valid = bus.req_valid;
    assign bus_s.req_write = bus.req_write;
    assign bus_s.req_addr  = bus.req_addr;
    assign bus_s.req_wdata = bus.req_wdata;

    int total = 0;
    int bad   = 0;
    int resp_pulses = 0;

    always @(negedge clk) if (bus.resp_valid) resp_pulses++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: per-set list of resident tags, most recently used first.
    logic [DATA_W-1:0] m_mem [MEMD];
    bit                m_known [MEMD];
    int                m_tag [SETS][WAYS];
    int                m_n [SETS];
    int                m_hits, m_misses;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) m_n[s] = 0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_front(input int s, input int pos, input int t);
        for (int i = pos; i > 0; i--) m_tag[s][i] = m_tag[s][i-1];
        m_tag[s][0] = t;
    endtask

    task automatic model_access(input bit wr, input int addr, input logic [DATA_W-1:0] wd,
                                output bit hit, output logic [DATA_W-1:0] rd, output bit known);
        int s, t, pos;
        s   = addr % SETS;
        t   = addr / SETS;
        pos = -1;
        for (int i = 0; i < m_n[s]; i++) if (m_tag[s][i] == t) pos = i;
        hit = (pos >= 0);
        if (wr) begin
            m_mem[addr]   = wd;
            m_known[addr] = 1'b1;
            rd            = '0;
            known         = 1'b1;
            if (hit) model_front(s, pos, t);
        end else begin
            rd    = m_mem[addr];
            known = m_known[addr];
            if (hit) begin
                model_front(s, pos, t);
                if (m_hits < CNT_MAX) m_hits++;
            end else begin
                if (m_n[s] < WAYS) m_n[s]++;
                model_front(s, m_n[s] - 1, t);
                if (m_misses < CNT_MAX) m_misses++;
            end
        end
    endtask

    task automatic do_req(input bit wr, input int addr, input logic [DATA_W-1:0] wd,
                          output bit hit, output logic [DATA_W-1:0] rd, output int lat);
        int n;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = ADDR_W'(addr);
        bus.req_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.resp_valid) check("resp_timeout", 32'd0, 32'd1);
        hit = bus.resp_hit;
        rd  = bus.resp_rdata;
        @(posedge clk);
        #1;
        check("resp_pulse_width", 32'(bus.resp_valid), 32'd0);
    endtask

    task automatic check_counts();
        check("hit_cnt", bus.hit_cnt, m_hits);
        check("miss_cnt", bus.miss_cnt, m_misses);
        check("sat_hit_cnt", bus_s.hit_cnt, (m_hits > SAT_MAX) ? SAT_MAX : m_hits);
        check("sat_miss_cnt", bus_s.miss_cnt, (m_misses > SAT_MAX) ? SAT_MAX : m_misses);
    endtask

    task automatic run_req(input bit wr, input int addr, input logic [DATA_W-1:0] wd,
                           output bit a_hit, output logic [DATA_W-1:0] a_rd, output int a_lat);
        bit e_hit, known;
        logic [DATA_W-1:0] e_rd;
        model_access(wr, addr, wd, e_hit, e_rd, known);
        do_req(wr, addr, wd, a_hit, a_rd, a_lat);
        check($sformatf("hit a=%0d", addr), 32'(a_hit), 32'(e_hit));
        if (known) check($sformatf("rdata a=%0d", addr), a_rd, e_rd);
        check($sformatf("latency a=%0d", addr), a_lat, (wr || e_hit) ? 1 : MISS_LAT + 1);
        check_counts();
    endtask

    typedef struct {
        bit          wr;
        int          addr;
        logic [31:0] wd;
        bit          e_hit;
        bit          chk;
        logic [31:0] e_rd;
        int          e_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit wr, input int addr, input logic [31:0] wd, input bit e_hit,
                       input bit chk, input logic [31:0] e_rd, input int e_lat);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wd = wd; v.e_hit = e_hit;
        v.chk = chk; v.e_rd = e_rd; v.e_lat = e_lat;
        vecs.push_back(v);
    endtask

    initial begin
        bit a_hit, h, k;
        logic [DATA_W-1:0] a_rd, r;
        int a_lat, n_low, p0;

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < MEMD; i++) m_known[i] = 1'b0;
        model_reset();

        // write/read basics
        add(1, 0, 32'd42, 0, 1, 32'd0, 1);
        add(0, 0, 32'd0, 0, 1, 32'd42, 5);
        add(0, 0, 32'd0, 1, 1, 32'd42, 1);
        // LRU in set 0
        add(0, 8, 0, 0, 0, 0, 5);
        add(0, 16, 0, 0, 0, 0, 5);
        add(0, 24, 0, 0, 0, 0, 5);
        add(0, 0, 0, 1, 1, 32'd42, 1);
        add(0, 32, 0, 0, 0, 0, 5);
        add(0, 0, 0, 1, 1, 32'd42, 1);
        add(0, 16, 0, 1, 0, 0, 1);
        add(0, 24, 0, 1, 0, 0, 1);
        add(0, 32, 0, 1, 0, 0, 1);
        add(0, 8, 0, 0, 0, 0, 5);
        // write hit / write miss without allocation
        add(0, 3, 0, 0, 0, 0, 5);
        add(1, 3, 32'd7, 1, 1, 32'd0, 1);
        add(0, 3, 0, 1, 1, 32'd7, 1);
        add(1, 11, 32'd99, 0, 1, 32'd0, 1);
        add(0, 11, 0, 0, 1, 32'd99, 5);
        // top of memory
        add(1, 1023, 32'hDEADBEEF, 0, 1, 32'd0, 1);
        add(0, 1023, 0, 0, 1, 32'hDEADBEEF, 5);
        add(0, 1023, 0, 1, 1, 32'hDEADBEEF, 1);

        @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'd0);
        check("rst_hit", 32'(bus.resp_hit), 32'd0);
        check_counts();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_req(vecs[i].wr, vecs[i].addr, vecs[i].wd, a_hit, a_rd, a_lat);
            check($sformatf("tbl%0d_hit", i), 32'(a_hit), 32'(vecs[i].e_hit));
            if (vecs[i].chk) check($sformatf("tbl%0d_rdata", i), a_rd, vecs[i].e_rd);
            check($sformatf("tbl%0d_lat", i), a_lat, vecs[i].e_lat);
        end
        check("tbl_final_hit_cnt", bus.hit_cnt, 32'd8);
        check("tbl_final_miss_cnt", bus.miss_cnt, 32'd9);
        check("tbl_sat_hit_cnt", bus_s.hit_cnt, 32'd3);

        // Backpressure: write held valid during a read miss to the same address.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = ADDR_W'(5);
        @(negedge clk);
        check("bp_ready_before", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_write = 1'b1;
        bus.req_wdata = 32'h1234;
        model_access(0, 5, 0, h, r, k);
        p0 = resp_pulses;
        n_low = 0;
        @(negedge clk);
        while (!bus.req_ready && n_low < 50) begin
            n_low++;
            @(negedge clk);
        end
        check("bp_ready_low_cycles", n_low, MISS_LAT + 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        model_access(1, 5, 32'h1234, h, r, k);
        check("bp_write_resp_valid", 32'(bus.resp_valid), 32'd1);
        check("bp_write_hit", 32'(bus.resp_hit), 32'(h));
        check("bp_write_rdata", bus.resp_rdata, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("bp_resp_count", resp_pulses - p0, 32'd2);
        check_counts();
        run_req(0, 5, 0, a_hit, a_rd, a_lat);

        // Reset two cycles into a fill.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = ADDR_W'(77);
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        p0 = resp_pulses;
        rst = 1'b1;
        #1;
        check("mfrst_ready", 32'(bus.req_ready), 32'd1);
        check("mfrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("mfrst_rdata", bus.resp_rdata, 32'd0);
        check("mfrst_hit", 32'(bus.resp_hit), 32'd0);
        model_reset();
        check_counts();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (MISS_LAT + 3) @(posedge clk);
        #1;
        check("mfrst_no_resp", resp_pulses - p0, 32'd0);
        run_req(0, 77, 0, a_hit, a_rd, a_lat);
        check("mfrst_reread_miss_cnt", bus.miss_cnt, 32'd1);
        run_req(0, 77, 0, a_hit, a_rd, a_lat);
        run_req(0, 77, 0, a_hit, a_rd, a_lat);
        run_req(0, 77, 0, a_hit, a_rd, a_lat);
        run_req(0, 77, 0, a_hit, a_rd, a_lat);
        run_req(0, 77, 0, a_hit, a_rd, a_lat);
        check("sat_after_5_hits", bus_s.hit_cnt, 32'd3);
        check("wide_after_5_hits", bus.hit_cnt, 32'd5);

        // Random traffic over six tags per set plus the top tag.
        for (int i = 0; i < 300; i++) begin
            int t, s;
            bit wr;
            t  = ($urandom_range(0, 9) == 0) ? (MEMD / SETS - 1) : $urandom_range(0, 5);
            s  = $urandom_range(0, SETS - 1);
            wr = ($urandom_range(0, 9) < 3);
            run_req(wr, t * SETS + s, $urandom, a_hit, a_rd, a_lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
